// File: rtl/encap_sched_arbiter.sv
// ---------------------------------------------------------------------------
// encap_sched_arbiter
//
// Round-robin scheduler that shares one encapsulator among NUM_REQ
// requesters. In IDLE it picks the first requesting port at or above rr_ptr
// (wrapping), captures that port's data word and destination address, and
// builds the link header {ROUTER_ID, frame_tag, TTL_INIT}. LAUNCH is a single
// cycle that raises start_encap_pkt together with the grant. WAIT then runs
// until encap_done, or until TIMEOUT_CYCLES cycles pass, and reports the
// result to the owning requester as a one-cycle done or error pulse.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req                   per-requester request level
//   req_data              flattened data words, slice i = requester i
//   req_dst_addr          flattened destination addresses, slice i = requester i
//   gnt                   one-hot grant, high during the LAUNCH cycle
//   req_done / req_err    one-hot completion / timeout pulses
//   busy                  high whenever the scheduler is not IDLE
//   data_arbiter_send     captured data word to the encapsulator
//   router_dst_addr_send  captured destination address to the encapsulator
//   header_pkt_send       captured link header
//   start_encap_pkt       one-cycle start pulse to the encapsulator
//   encap_done            completion pulse from the encapsulator
// ---------------------------------------------------------------------------
module encap_sched_arbiter #(
    parameter int NUM_REQ                = 4,
    parameter int DATA_WIDTH             = 1024,
    parameter int ADDR_WIDTH             = 10,
    parameter int RECOGNIZE_ROUTER_WIDTH = 2,
    parameter int NUMBER_PACKET          = 19,
    parameter int TTL_WIDTH              = $clog2(3),
    parameter int HEADER_WIDTH           = RECOGNIZE_ROUTER_WIDTH + $clog2(NUMBER_PACKET) + TTL_WIDTH,
    parameter logic [RECOGNIZE_ROUTER_WIDTH-1:0] ROUTER_ID = 2'b10,
    parameter logic [TTL_WIDTH-1:0]              TTL_INIT  = 2'b01,
    parameter int TIMEOUT_CYCLES         = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_dst_addr,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               req_done,
    output logic [NUM_REQ-1:0]               req_err,
    output logic                             busy,
    output logic [DATA_WIDTH-1:0]            data_arbiter_send,
    output logic [ADDR_WIDTH-1:0]            router_dst_addr_send,
    output logic [HEADER_WIDTH-1:0]          header_pkt_send,
    output logic                             start_encap_pkt,
    input  logic                             encap_done
);

    localparam int TAG_WIDTH = $clog2(NUMBER_PACKET);
    localparam int PTR_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [TAG_WIDTH-1:0] TAG_LAST = TAG_WIDTH'(NUMBER_PACKET - 1);
    localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(NUM_REQ - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PTR_WIDTH-1:0]  rr_ptr;
    logic [PTR_WIDTH-1:0]  winner;
    logic [PTR_WIDTH-1:0]  pick;
    logic                  found;
    int                    cand;
    logic [DATA_WIDTH-1:0] pick_data;
    logic [ADDR_WIDTH-1:0] pick_addr;
    logic [TAG_WIDTH-1:0]  frame_tag;
    logic [CNT_WIDTH-1:0]  wait_cnt, wait_cnt_d;
    logic                  capture, finish_ok, finish_err;
    logic [NUM_REQ-1:0]    winner_oh;

    // Rotating priority search: offset 0 is rr_ptr itself, so the port served
    // last has the lowest priority next time.
    // NOTE: every combinational output gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr;
        cand  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && req[PTR_WIDTH'(cand)]) begin
                found = 1'b1;
                pick  = PTR_WIDTH'(cand);
            end
        end
    end

    // Constant-index mux keeps the slice selection free of variable part-selects.
    always_comb begin
        pick_data = '0;
        pick_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == PTR_WIDTH'(i)) begin
                pick_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                pick_addr = req_dst_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Next-state logic. encap_done only matters in WAIT; req only in IDLE.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt;
        capture    = 1'b0;
        finish_ok  = 1'b0;
        finish_err = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    capture = 1'b1;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt + 1'b1;
                // Done is checked first so a same-cycle done beats the timeout.
                if (encap_done) begin
                    finish_ok = 1'b1;
                    state_d   = ST_IDLE;
                end else if (wait_cnt == CNT_LAST) begin
                    finish_err = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Decoded from the state register so an asynchronous reset clears them at once.
    assign winner_oh       = NUM_REQ'(1) << winner;
    assign busy            = (state_q != ST_IDLE);
    assign start_encap_pkt = (state_q == ST_LAUNCH);
    assign gnt             = start_encap_pkt ? winner_oh : '0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wait_cnt  <= '0;
            rr_ptr    <= '0;
            frame_tag <= '0;
            req_done  <= '0;
            req_err   <= '0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= wait_cnt_d;
            req_done <= finish_ok  ? winner_oh : '0;
            req_err  <= finish_err ? winner_oh : '0;
            if (finish_ok || finish_err) begin
                rr_ptr    <= (winner == PTR_LAST) ? '0 : winner + 1'b1;
                frame_tag <= (frame_tag == TAG_LAST) ? '0 : frame_tag + 1'b1;
            end
        end
    end

    // NOTE: the wide capture registers are reset too, because the encapsulator
    // side must read all-zero outputs while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winner               <= '0;
            data_arbiter_send    <= '0;
            router_dst_addr_send <= '0;
            header_pkt_send      <= '0;
        end else if (capture) begin
            winner               <= pick;
            data_arbiter_send    <= pick_data;
            router_dst_addr_send <= pick_addr;
            header_pkt_send      <= {ROUTER_ID, frame_tag, TTL_INIT};
        end
    end

endmodule

// File: tb/tb_encap_sched_arbiter.sv
// ---------------------------------------------------------------------------
// tb_encap_sched_arbiter
//
// Directed bench for encap_sched_arbiter with default parameters. Each
// expected grant (port, header, data, address) is pushed to a scoreboard
// queue when the request is driven and popped when gnt appears. The bench
// keeps its own frame-tag count to predict headers.
// ---------------------------------------------------------------------------
module tb_encap_sched_arbiter;

    localparam int N  = 4;
    localparam int DW = 1024;
    localparam int AW = 10;
    localparam int HW = 9;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [N*DW-1:0]   req_data;
    logic [N*AW-1:0]   req_dst_addr;
    logic [N-1:0]      gnt;
    logic [N-1:0]      req_done;
    logic [N-1:0]      req_err;
    logic              busy;
    logic [DW-1:0]     data_arbiter_send;
    logic [AW-1:0]     router_dst_addr_send;
    logic [HW-1:0]     header_pkt_send;
    logic              start_encap_pkt;
    logic              encap_done;

    encap_sched_arbiter dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .req                  (req),
        .req_data             (req_data),
        .req_dst_addr         (req_dst_addr),
        .gnt                  (gnt),
        .req_done             (req_done),
        .req_err              (req_err),
        .busy                 (busy),
        .data_arbiter_send    (data_arbiter_send),
        .router_dst_addr_send (router_dst_addr_send),
        .header_pkt_send      (header_pkt_send),
        .start_encap_pkt      (start_encap_pkt),
        .encap_done           (encap_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  gnt;
        logic [HW-1:0] hdr;
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    logic [4:0] exp_tag  = 5'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reports only the first differing 64-bit chunk to keep the line short.
    task automatic check_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        int k;
        checks++;
        assert (obs === exp) else begin
            failures++;
            k = 0;
            for (int c = DW/64 - 1; c >= 0; c--)
                if (obs[c*64 +: 64] !== exp[c*64 +: 64]) k = c;
            $error("FAIL %s chunk%0d observed=%h expected=%h", tag, k, obs[k*64 +: 64], exp[k*64 +: 64]);
        end
    endtask

    function automatic logic [DW-1:0] slice_data(input int i);
        logic [255:0] pat;
        pat = 256'h1111111122222222333333334444444455555555666666667777777788888888;
        if (i == 2) return {4{pat}};
        return {32{32'hC0DE0000 | 32'(i)}};
    endfunction

    function automatic logic [AW-1:0] addr_of(input int i);
        if (i == 2) return 10'd1;
        return AW'(256 + i * 7);
    endfunction

    function automatic logic [HW-1:0] hdr_of(input logic [4:0] t);
        return {2'b10, t, 2'b01};
    endfunction

    task automatic expect_port(input int p);
        exp_t e;
        e.gnt  = N'(1) << p;
        e.hdr  = hdr_of(exp_tag);
        e.data = slice_data(p);
        e.addr = addr_of(p);
        sb.push_back(e);
    endtask

    task automatic advance_tag();
        exp_tag = (exp_tag == 5'd18) ? 5'd0 : exp_tag + 5'd1;
    endtask

    // Waits (bounded) for a grant and checks it against the scoreboard head.
    task automatic wait_grant();
        exp_t e;
        int   n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == '0 && n < 100);
        check("sb_depth", 64'(sb.size()), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("gnt", 64'(gnt), 64'(e.gnt));
            check("start", 64'(start_encap_pkt), 64'd1);
            check("busy_launch", 64'(busy), 64'd1);
            check("header", 64'(header_pkt_send), 64'(e.hdr));
            check("addr", 64'(router_dst_addr_send), 64'(e.addr));
            check_data("data", data_arbiter_send, e.data);
        end
    endtask

    // Called at the grant (LAUNCH) negedge; encap_done sampled d edges after WAIT entry.
    task automatic run_frame(input int d, input bit launch_done, input logic [N-1:0] port_oh);
        bit bad;
        if (launch_done) encap_done = 1'b1;
        @(negedge clk);
        encap_done = 1'b0;
        check("gnt_one_cycle", 64'(gnt), 64'd0);
        check("start_one_cycle", 64'(start_encap_pkt), 64'd0);
        check("busy_wait", 64'(busy), 64'd1);
        bad = 1'b0;
        repeat (d - 1) begin
            @(negedge clk);
            if (req_done != '0 || req_err != '0 || busy !== 1'b1) bad = 1'b1;
        end
        encap_done = 1'b1;
        @(negedge clk);
        encap_done = 1'b0;
        check("wait_quiet", 64'(bad), 64'd0);
        check("req_done", 64'(req_done), 64'(port_oh));
        check("req_err_none", 64'(req_err), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
        advance_tag();
    endtask

    // Called at the grant negedge; no encap_done is ever driven.
    task automatic run_timeout(input logic [N-1:0] port_oh);
        bit bad;
        @(negedge clk);
        bad = 1'b0;
        repeat (63) begin
            @(negedge clk);
            if (req_done != '0 || req_err != '0 || busy !== 1'b1) bad = 1'b1;
        end
        @(negedge clk);
        check("timeout_quiet", 64'(bad), 64'd0);
        check("req_err", 64'(req_err), 64'(port_oh));
        check("req_done_none", 64'(req_done), 64'd0);
        check("busy_after_err", 64'(busy), 64'd0);
        advance_tag();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        exp_tag = 5'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        req          = '0;
        encap_done   = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW]     = slice_data(i);
            req_dst_addr[i*AW +: AW] = addr_of(i);
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_start", 64'(start_encap_pkt), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(req_done), 64'd0);
        check("rst_err", 64'(req_err), 64'd0);
        check("rst_header", 64'(header_pkt_send), 64'd0);
        check("rst_addr", 64'(router_dst_addr_send), 64'd0);
        check_data("rst_data", data_arbiter_send, '0);
        rst_n   = 1'b1;
        exp_tag = 5'd0;

        // Single request on port 2
        @(negedge clk);
        req = 4'b0100;
        expect_port(2);
        wait_grant();
        req = '0;
        run_frame(19, 1'b0, 4'b0100);
        @(negedge clk);
        check("single_idle_busy", 64'(busy), 64'd0);
        check("single_done_pulse", 64'(req_done), 64'd0);

        // Full contention, 20 frames: order 0,1,2,3,... and tag wrap 18 -> 0
        do_reset();
        req = 4'b1111;
        for (int f = 0; f < 20; f++) begin
            expect_port(f % N);
            wait_grant();
            run_frame(19, 1'b0, N'(1) << (f % N));
        end
        req = '0;

        // Timeout A on port 0, then rr_ptr=1 and tag=1 seen on the next grant
        do_reset();
        req = 4'b0001;
        expect_port(0);
        wait_grant();
        req = '0;
        run_timeout(4'b0001);
        req = 4'b1111;
        expect_port(1);
        wait_grant();
        req = '0;
        run_frame(19, 1'b0, 4'b0010);

        // Timeout B: done on the 64th WAIT cycle wins over the timeout
        req = 4'b0001;
        expect_port(0);
        wait_grant();
        req = '0;
        run_frame(64, 1'b0, 4'b0001);

        // Spurious done in IDLE and in LAUNCH
        @(negedge clk);
        encap_done = 1'b1;
        @(negedge clk);
        encap_done = 1'b0;
        check("spur_idle_busy", 64'(busy), 64'd0);
        check("spur_idle_done", 64'(req_done), 64'd0);
        req = 4'b0100;
        expect_port(2);
        wait_grant();
        req = '0;
        run_frame(19, 1'b1, 4'b0100);

        // Reset mid-WAIT
        req = 4'b0010;
        expect_port(1);
        wait_grant();
        req = '0;
        repeat (5) @(negedge clk);
        check("midwait_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_gnt", 64'(gnt), 64'd0);
        check("arst_start", 64'(start_encap_pkt), 64'd0);
        check("arst_done", 64'(req_done), 64'd0);
        check("arst_err", 64'(req_err), 64'd0);
        check("arst_header", 64'(header_pkt_send), 64'd0);
        check_data("arst_data", data_arbiter_send, '0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_tag = 5'd0;
        req     = 4'b1000;
        expect_port(3);
        wait_grant();
        req = '0;
        run_frame(19, 1'b0, 4'b1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
